// File: rtl/proc_param.sv
// Multi-cycle register-file processor: accepts one instruction per run request,
// executes it over one to three EXEC states and pulses done (and err for illegal opcodes).
module proc_param #(
    parameter  int DATA_W = 16,
    parameter  int NREG   = 8,
    localparam int RW     = $clog2(NREG),
    localparam int IR_W   = 4 + 2 * RW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [IR_W-1:0]   ir,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] g,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_n,
    input  logic [RW-1:0]     dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC1, S_EXEC2, S_EXEC3} state_t;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_MVI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_MVNZ = 4'd7;
    localparam logic [3:0] OP_CMP  = 4'd8;

    state_t            state_r, state_next_s;
    logic [DATA_W-1:0] regs_r [NREG];
    logic [IR_W-1:0]   ir_r;
    logic [DATA_W-1:0] a_r, g_r;
    logic              z_r, c_r, n_r;
    logic              busy_r, done_r, err_r;

    logic [3:0]        op_s;
    logic [RW-1:0]     x_s, y_s;
    logic [DATA_W-1:0] rx_s, ry_s;
    logic [DATA_W:0]   sum_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_c_s;
    logic              done_next_s, err_next_s;
    logic              load_ir_s, load_a_s, load_g_s, wr_en_s;
    logic [DATA_W-1:0] wr_data_s;

    assign op_s     = ir_r[IR_W-1 -: 4];
    assign x_s      = ir_r[2*RW-1 -: RW];
    assign y_s      = ir_r[RW-1:0];
    assign rx_s     = regs_r[x_s];
    assign ry_s     = regs_r[y_s];
    assign dbg_data = regs_r[dbg_sel];

    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;
    assign ir     = ir_r;
    assign a      = a_r;
    assign g      = g_r;
    assign flag_z = z_r;
    assign flag_c = c_r;
    assign flag_n = n_r;

    // ALU: result and carry/borrow of a against R[y]
    always_comb begin
        sum_s     = '0;
        alu_res_s = '0;
        alu_c_s   = 1'b0;
        case (op_s)
            OP_ADD: begin
                sum_s     = {1'b0, a_r} + {1'b0, ry_s};
                alu_res_s = sum_s[DATA_W-1:0];
                alu_c_s   = sum_s[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                alu_res_s = a_r - ry_s;
                alu_c_s   = (a_r < ry_s);
            end
            OP_AND:  alu_res_s = a_r & ry_s;
            OP_OR:   alu_res_s = a_r | ry_s;
            OP_XOR:  alu_res_s = a_r ^ ry_s;
            default: alu_res_s = '0;
        endcase
    end

    // Next-state and datapath control decode
    always_comb begin
        state_next_s = state_r;
        done_next_s  = 1'b0;
        err_next_s   = 1'b0;
        load_ir_s    = 1'b0;
        load_a_s     = 1'b0;
        load_g_s     = 1'b0;
        wr_en_s      = 1'b0;
        wr_data_s    = '0;
        case (state_r)
            S_IDLE: begin
                if (run) begin
                    load_ir_s    = 1'b1;
                    state_next_s = S_EXEC1;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_EXEC1: begin
                state_next_s = S_IDLE;
                done_next_s  = 1'b1;
                case (op_s)
                    OP_MV: begin
                        wr_en_s   = 1'b1;
                        wr_data_s = ry_s;
                    end
                    OP_MVI: begin
                        wr_en_s   = 1'b1;
                        wr_data_s = din;
                    end
                    OP_MVNZ: begin
                        wr_en_s   = ~z_r;
                        wr_data_s = ry_s;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP: begin
                        load_a_s     = 1'b1;
                        done_next_s  = 1'b0;
                        state_next_s = S_EXEC2;
                    end
                    default: err_next_s = 1'b1;
                endcase
            end
            S_EXEC2: begin
                load_g_s = 1'b1;
                if (op_s == OP_CMP) begin
                    done_next_s  = 1'b1;
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_EXEC3;
                end
            end
            S_EXEC3: begin
                wr_en_s      = 1'b1;
                wr_data_s    = g_r;
                done_next_s  = 1'b1;
                state_next_s = S_IDLE;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, architectural registers and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
            ir_r   <= '0;
            a_r    <= '0;
            g_r    <= '0;
            z_r    <= 1'b0;
            c_r    <= 1'b0;
            n_r    <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != S_IDLE);
            done_r  <= done_next_s;
            err_r   <= err_next_s;
            if (load_ir_s) begin
                ir_r <= din[DATA_W-1 -: IR_W];
            end
            if (load_a_s) begin
                a_r <= rx_s;
            end
            if (load_g_s) begin
                g_r <= alu_res_s;
                z_r <= (alu_res_s == '0);
                c_r <= alu_c_s;
                n_r <= alu_res_s[DATA_W-1];
            end
            if (wr_en_s) begin
                regs_r[x_s] <= wr_data_s;
            end
        end
    end

endmodule

// File: tb/tb_proc_param.sv
// Self-checking bench for proc_param: directed scenarios plus randomized
// instruction streams compared against an instruction-level reference model.
`timescale 1ns/1ps
module tb_proc_param;
    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int RW     = 3;
    localparam int IR_W   = 10;

    logic              clock;
    logic              reset;
    logic              run;
    logic [DATA_W-1:0] din;
    logic              busy, done, err;
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] a, g;
    logic              flag_z, flag_c, flag_n;
    logic [RW-1:0]     dbg_sel;
    logic [DATA_W-1:0] dbg_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: architectural state only
    logic [DATA_W-1:0] m_r [NREG];
    logic              m_z, m_c, m_n;
    logic [DATA_W-1:0] m_a, m_g;
    logic [IR_W-1:0]   m_ir;

    proc_param #(.DATA_W(DATA_W), .NREG(NREG)) dut (
        .clock(clock), .reset(reset), .run(run), .din(din),
        .busy(busy), .done(done), .err(err), .ir(ir), .a(a), .g(g),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    function automatic logic [15:0] enc(input int op, input int x, input int y);
        return 16'((op << 12) | (x << 9) | (y << 6));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) m_r[i] = '0;
        m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;
        m_a = '0; m_g = '0; m_ir = '0;
    endfunction

    // Executes one instruction on the model; returns done latency and err
    function automatic void model_exec(input int op, input int x, input int y,
                                       input logic [15:0] imm, output int lat, output bit e);
        int ai, bi, r;
        logic [15:0] w;
        w = enc(op, x, y);
        m_ir = w[15:6];
        lat = 1; e = 1'b0;
        ai = int'(m_r[x]); bi = int'(m_r[y]);
        r = 0;
        case (op)
            0: m_r[x] = m_r[y];
            1: m_r[x] = imm;
            7: if (!m_z) m_r[x] = m_r[y];
            2, 3, 4, 5, 6, 8: begin
                m_c = 1'b0;
                case (op)
                    2: begin r = ai + bi; m_c = (r >= 65536); r = r % 65536; end
                    3, 8: begin m_c = (ai < bi); r = (ai - bi + 65536) % 65536; end
                    4: r = ai & bi;
                    5: r = ai | bi;
                    default: r = ai ^ bi;
                endcase
                m_a = 16'(ai);
                m_g = 16'(r);
                m_z = (r == 0);
                m_n = (r >= 32768);
                if (op == 8) lat = 2;
                else begin lat = 3; m_r[x] = 16'(r); end
            end
            default: e = 1'b1;
        endcase
    endfunction

    // Issue one instruction, wait for done, compare timing and full architectural state
    task automatic issue(input int op, input int x, input int y,
                         input logic [15:0] imm, input string tag);
        int lat, n;
        bit e, got;
        model_exec(op, x, y, imm, lat, e);
        din = enc(op, x, y);
        run = 1'b1;
        @(posedge clock); #1;
        run = 1'b0;
        din = imm;
        n = 0; got = 1'b0;
        while (!got && n < 6) begin
            @(posedge clock); #1;
            n++;
            din = 16'($urandom);
            if (done) got = 1'b1;
            else begin
                total_cnt++;
                if (busy !== 1'b1 || err !== 1'b0)
                    $display("FAIL %s in_flight: busy=%b err=%b expected busy=1 err=0", tag, busy, err);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (!got) $display("FAIL %s done_timeout: no done within %0d cycles, expected at %0d", tag, n, lat);
        else if (n != lat) $display("FAIL %s latency: got %0d expected %0d", tag, n, lat);
        else pass_cnt++;
        total_cnt++;
        if (err !== e) $display("FAIL %s err: got %b expected %b", tag, err, e);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b expected 0", tag, busy);
        else pass_cnt++;
        total_cnt++;
        if (ir !== m_ir) $display("FAIL %s ir: got %h expected %h", tag, ir, m_ir);
        else pass_cnt++;
        for (int i = 0; i < NREG; i++) begin
            dbg_sel = 3'(i);
            #0.5;
            total_cnt++;
            if (dbg_data !== m_r[i]) $display("FAIL %s R%0d: got %h expected %h", tag, i, dbg_data, m_r[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if ({flag_z, flag_c, flag_n} !== {m_z, m_c, m_n})
            $display("FAIL %s flags: got zcn=%b%b%b expected %b%b%b", tag, flag_z, flag_c, flag_n, m_z, m_c, m_n);
        else pass_cnt++;
        total_cnt++;
        if (a !== m_a || g !== m_g) $display("FAIL %s a_g: got a=%h g=%h expected a=%h g=%h", tag, a, g, m_a, m_g);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        for (int i = 0; i < NREG; i++) begin
            dbg_sel = 3'(i);
            #0.5;
            total_cnt++;
            if (dbg_data !== 16'h0000) $display("FAIL reset R%0d: got %h expected 0000", i, dbg_data);
            else pass_cnt++;
        end
        total_cnt++;
        if (a !== 16'h0 || g !== 16'h0 || ir !== 10'h0)
            $display("FAIL reset a_g_ir: got a=%h g=%h ir=%h expected all 0", a, g, ir);
        else pass_cnt++;
        total_cnt++;
        if ({flag_z, flag_c, flag_n, busy, done, err} !== 6'b0)
            $display("FAIL reset status: got zcn=%b%b%b busy=%b done=%b err=%b expected 0", flag_z, flag_c, flag_n, busy, done, err);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_directed();
        issue(1, 0, 0, 16'h1234, "mvi_r0");
        dbg_sel = 3'd0; #0.5;
        total_cnt++;
        if (dbg_data !== 16'h1234) $display("FAIL mvi_r0_value: got %h expected 1234", dbg_data);
        else pass_cnt++;
        issue(1, 1, 0, 16'hFFFF, "mvi_r1");
        issue(1, 2, 0, 16'h0001, "mvi_r2");
        issue(2, 1, 2, 16'h0000, "add_r1_r2");
        dbg_sel = 3'd1; #0.5;
        total_cnt++;
        if (dbg_data !== 16'h0000 || {flag_z, flag_c, flag_n} !== 3'b110)
            $display("FAIL add_wrap: got R1=%h zcn=%b%b%b expected 0000 110", dbg_data, flag_z, flag_c, flag_n);
        else pass_cnt++;
        issue(1, 3, 0, 16'h0005, "mvi_r3");
        issue(1, 4, 0, 16'h0007, "mvi_r4");
        issue(3, 3, 4, 16'h0000, "sub_r3_r4");
        dbg_sel = 3'd3; #0.5;
        total_cnt++;
        if (dbg_data !== 16'hFFFE || {flag_z, flag_c, flag_n} !== 3'b011)
            $display("FAIL sub_borrow: got R3=%h zcn=%b%b%b expected fffe 011", dbg_data, flag_z, flag_c, flag_n);
        else pass_cnt++;
        issue(1, 5, 0, 16'h00AA, "mvi_r5");
        issue(1, 6, 0, 16'h00AA, "mvi_r6");
        issue(1, 7, 0, 16'h5555, "mvi_r7");
        issue(8, 5, 6, 16'h0000, "cmp_equal");
        issue(7, 7, 5, 16'h0000, "mvnz_blocked");
        dbg_sel = 3'd7; #0.5;
        total_cnt++;
        if (dbg_data !== 16'h5555 || flag_z !== 1'b1)
            $display("FAIL mvnz_blocked_value: got R7=%h z=%b expected 5555 1", dbg_data, flag_z);
        else pass_cnt++;
        issue(1, 6, 0, 16'h00AB, "mvi_r6b");
        issue(8, 5, 6, 16'h0000, "cmp_differ");
        issue(7, 7, 5, 16'h0000, "mvnz_taken");
        dbg_sel = 3'd7; #0.5;
        total_cnt++;
        if (dbg_data !== 16'h00AA || flag_z !== 1'b0)
            $display("FAIL mvnz_taken_value: got R7=%h z=%b expected 00aa 0", dbg_data, flag_z);
        else pass_cnt++;
        issue(1, 1, 0, 16'h0003, "mvi_r1b");
        issue(2, 1, 1, 16'h0000, "add_self");
        issue(0, 2, 7, 16'h0000, "mv_r2_r7");
    endtask

    task automatic test_illegal();
        issue(15, 2, 3, 16'hBEEF, "illegal_f");
        issue(9, 4, 4, 16'h1111, "illegal_9");
        @(posedge clock); #1;
        total_cnt++;
        if (done !== 1'b0 || err !== 1'b0)
            $display("FAIL illegal_pulse_width: got done=%b err=%b expected 0 0", done, err);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int dcnt;
        din = enc(2, 1, 2);
        run = 1'b1;
        @(posedge clock); #1;
        run = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            reset = 1'b0;
            if (done) dcnt++;
        end
        model_reset();
        total_cnt++;
        if (dcnt != 0 || busy !== 1'b0) $display("FAIL abort_no_done: got %0d done pulses busy=%b expected 0 0", dcnt, busy);
        else pass_cnt++;
        for (int i = 0; i < NREG; i++) begin
            dbg_sel = 3'(i);
            #0.5;
            total_cnt++;
            if (dbg_data !== 16'h0000) $display("FAIL abort_R%0d: got %h expected 0000", i, dbg_data);
            else pass_cnt++;
        end
        issue(1, 6, 0, 16'hC0DE, "mvi_after_reset");
    endtask

    task automatic test_run_ignored();
        int dcnt, lat;
        bit e;
        model_exec(2, 2, 3, 16'h0000, lat, e);
        din = enc(2, 2, 3);
        run = 1'b1;
        @(posedge clock); #1;
        run = 1'b0;
        dcnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock); #1;
            if (done) dcnt++;
            if (k == 1) begin run = 1'b1; din = enc(1, 4, 0); end
            else if (k == 2) begin run = 1'b0; din = 16'h7777; end
        end
        total_cnt++;
        if (dcnt != 1) $display("FAIL run_ignored_done_count: got %0d expected 1", dcnt);
        else pass_cnt++;
        for (int i = 0; i < NREG; i++) begin
            dbg_sel = 3'(i);
            #0.5;
            total_cnt++;
            if (dbg_data !== m_r[i]) $display("FAIL run_ignored_R%0d: got %h expected %h", i, dbg_data, m_r[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random_back_to_back();
        int op;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) op = int'($urandom_range(9, 15));
            else op = int'($urandom_range(0, 8));
            issue(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  16'($urandom), "random");
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock); #1;
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        run     = 1'b0;
        din     = '0;
        dbg_sel = '0;
        model_reset();
        test_reset();
        test_directed();
        test_illegal();
        test_reset_abort();
        test_run_ignored();
        test_random_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/proc_param.md
PROC_PARAM -- requirements
Module: proc_param

Interface
REQ-001 Parameter DATA_W, default 16: datapath and register width; SHALL be >= IR_W.
REQ-002 Parameter NREG, default 8: number of general registers; power of 2, >= 2. RW = clog2(NREG).
REQ-003 Derived IR_W = 4 + 2*RW; instruction word = din[DATA_W-1 -: IR_W]: opcode[3:0], then x[RW-1:0], then y[RW-1:0].
REQ-004 clock  in  1  sole clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 run  in  1  start request, sampled only in IDLE.
REQ-007 din  in  DATA_W  instruction word in the accept cycle; immediate operand in the EXEC1 cycle.
REQ-008 busy  out  1  high whenever state != IDLE.
REQ-009 done  out  1  registered one-cycle completion pulse.
REQ-010 err  out  1  registered one-cycle pulse, coincident with done, for an illegal opcode.
REQ-011 ir  out  IR_W  current instruction register.
REQ-012 a, g  out  DATA_W each  operand register A and result register G.
REQ-013 flag_z, flag_c, flag_n  out  1 each  zero, carry/borrow and negative flags.
REQ-014 dbg_sel  in  RW; dbg_data  out  DATA_W  combinational read of R[dbg_sel].

Function
REQ-015 FSM states: IDLE, EXEC1, EXEC2, EXEC3.
REQ-016 IDLE with run=1 at an edge: ir <= instruction field, state <= EXEC1. IDLE with run=0 holds all registers.
REQ-017 run is ignored while busy=1; no queuing.
REQ-018 Opcodes: 0 mv, 1 mvi, 2 add, 3 sub, 4 and, 5 or, 6 xor, 7 mvnz, 8 cmp. Opcodes 9-15 are illegal.
REQ-019 EXEC1 actions:
- mv: R[x] <= R[y].
- mvi: R[x] <= din.
- mvnz: R[x] <= R[y] only if flag_z=0.
- Each of these, and any illegal opcode: done <= 1, then IDLE. Illegal also sets err <= 1 and writes no register.
REQ-020 EXEC1 for ALU ops (add, sub, and, or, xor, cmp): a <= R[x], state <= EXEC2.
REQ-021 EXEC2: g <= a op R[y] and flags update. cmp then pulses done and returns to IDLE without writeback; the other ALU ops go to EXEC3.
REQ-022 EXEC3: R[x] <= g, done <= 1, state <= IDLE.
REQ-023 Latency, counted from the run-accept edge:
- done high after edge +1 for mv, mvi, mvnz and illegal.
- done high after edge +2 for cmp.
- done high after edge +3 for add, sub, and, or, xor.
REQ-024 Arithmetic:
- add: {C, result} = a + R[y], full DATA_W+1 bits.
- sub and cmp: result = a - R[y] mod 2^DATA_W; C = 1 iff a < R[y] unsigned (borrow).
- Logic ops: C = 0.
- All ALU ops: Z = (result == 0); N = result[DATA_W-1].
REQ-025 Flags change only in EXEC2; mv, mvi, mvnz and illegal opcodes leave flags unchanged.
REQ-026 x == y is legal: operands are read before write; e.g. add R1,R1 doubles R1.
REQ-027 done and err are low in every cycle other than the completion cycle.
REQ-028 A new run may be accepted in the same cycle done is high, because state is then IDLE, allowing back-to-back instructions.

Reset
REQ-029 reset=1 at an edge forces:
- state IDLE;
- all R[i], a, g, ir = 0;
- flags = 0;
- busy, done, err = 0.
REQ-030 Reset has priority over run and over any state action; reset during EXEC1-3 aborts the instruction with no done pulse.
REQ-031 The first run accepted after reset deasserts executes normally.

Verification (DATA_W=16, NREG=8: opcode din[15:12], x din[11:9], y din[8:6])
REQ-032 mvi R0: run with din=0x1000, next cycle din=0x1234 -> R0=0x1234, done after edge +1, flags unchanged.
REQ-033 add R1,R2 with R1=0xFFFF, R2=0x0001 (din=0x2280) -> R1=0x0000, Z=1, C=1, N=0, done after edge +3.
REQ-034 sub R3,R4 with R3=0x0005, R4=0x0007 (din=0x3700) -> R3=0xFFFE, N=1, C=1, Z=0.
REQ-035 cmp R5,R6 with both 0x00AA, then mvnz R7,R5 -> Z=1, R7 unchanged. Repeat with R6=0x00AB -> Z=0, R7=0x00AA; cmp writes no register.
REQ-036 Reset asserted in EXEC2 of an add -> no done pulse, all registers 0, busy=0; the next mvi completes correctly.
REQ-037 Opcode 0xF -> done=err=1 for one cycle after edge +1, registers unchanged; run pulsed during an add's EXEC2 -> ignored, exactly one done pulse.
